// File: rtl/seq_signed_divider.sv
// Iterative radix-2 non-restoring signed divider, one quotient bit per clock.
// Fixed latency of WIDTH+3 cycles from accepted start to the done pulse.
module seq_signed_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  // Partial remainder needs two extra bits: one for the magnitude, one for sign.
  localparam int unsigned RW = WIDTH + 2;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, CALC, FIX} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] dvd_q, dvs_q;
  logic [WIDTH:0]   dvs_mag;
  logic [WIDTH-1:0] qm;
  logic [RW-1:0]    rem;
  logic [CW-1:0]    cnt;
  logic             sgn_dvd, sgn_dvs;

  logic [WIDTH-1:0] dvd_abs_c, dvs_abs_c;
  logic [RW-1:0]    shifted_c, step_c;
  logic [WIDTH-1:0] r_mag_c, q_res_c, r_res_c;
  logic             dz_c, ov_c;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    state_nx = CALC;
      CALC:    if (cnt == CW'(WIDTH - 1)) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand magnitudes, one non-restoring step, and sign/special-case fixup.
  always_comb begin
    dvd_abs_c = dvd_q[WIDTH-1] ? WIDTH'(-dvd_q) : dvd_q;
    dvs_abs_c = dvs_q[WIDTH-1] ? WIDTH'(-dvs_q) : dvs_q;
    shifted_c = {rem[RW-2:0], qm[WIDTH-1]};
    step_c    = rem[RW-1] ? shifted_c + RW'(dvs_mag) : shifted_c - RW'(dvs_mag);
    // Restore a negative final remainder; only the low WIDTH bits are significant.
    r_mag_c   = rem[RW-1] ? WIDTH'(rem) + WIDTH'(dvs_mag) : WIDTH'(rem);
    q_res_c   = (sgn_dvd ^ sgn_dvs) ? WIDTH'(-qm) : qm;
    r_res_c   = sgn_dvd ? WIDTH'(-r_mag_c) : r_mag_c;
    dz_c      = (dvs_q == '0);
    ov_c      = (dvd_q == {1'b1, {(WIDTH-1){1'b0}}}) && (dvs_q == '1);
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_q       <= '0;
      dvs_q       <= '0;
      dvs_mag     <= '0;
      qm          <= '0;
      rem         <= '0;
      cnt         <= '0;
      sgn_dvd     <= 1'b0;
      sgn_dvs     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      busy <= (state_nx != IDLE);
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
          end
        end
        LOAD: begin
          qm      <= dvd_abs_c;
          dvs_mag <= {1'b0, dvs_abs_c};
          sgn_dvd <= dvd_q[WIDTH-1];
          sgn_dvs <= dvs_q[WIDTH-1];
          rem     <= '0;
          cnt     <= '0;
        end
        CALC: begin
          rem <= step_c;
          qm  <= {qm[WIDTH-2:0], ~step_c[RW-1]};
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          done        <= 1'b1;
          div_by_zero <= dz_c;
          overflow    <= ov_c;
          if (dz_c) begin
            quotient  <= '1;
            remainder <= dvd_q;
          end else begin
            quotient  <= q_res_c;
            remainder <= r_res_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
